mult_hilo_unit: RTL and testbench

//   Sequential wrapper that sits directly upstream of the 32x32 signed combinational multiplier.
//   - Registers the operands and holds them stable while the multiplier settles (multicycle path).
//   - Derives the unsigned product from the signed product.
//   - Writes the 64-bit result into architectural HI/LO registers and services MTHI/MTLO writes.
//   - Raises busy so the pipeline stalls HI/LO readers.

---
 rtl/mult_hilo_unit.sv | 153 +++++++++++++++
 tb/tb_mult_hilo_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_unit.sv
// HI/LO multiply wrapper. It registers the operands and holds them across a multicycle
// signed multiplier, corrects the product for unsigned multiplies, and owns HI/LO.

module mult_hilo_signed32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;

    assign a_ext   = {{32{a[31]}}, a};
    assign b_ext   = {{32{b[31]}}, b};
    assign product = a_ext * b_ext;
endmodule

module mult_hilo_unit #(
    parameter int MULT_CYCLES = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    if (MULT_CYCLES < 1 || MULT_CYCLES > 16) begin : g_bad_mult_cycles
        $error("mult_hilo_unit: MULT_CYCLES=%0d is illegal (legal range 1..16)", MULT_CYCLES);
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } op_t;

    localparam logic [3:0] COUNT_LOAD = 4'(MULT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        unsigned_q, unsigned_d;

    op_t         op_e;
    logic [63:0] product;
    logic [63:0] fix_a;
    logic [63:0] fix_b;
    logic [63:0] result;

    assign op_e = op_t'(op);

    // The multiplier only sees the operand registers, so it has MULT_CYCLES to settle.
    mult_hilo_signed32 u_mult (
        .a       (a_q),
        .b       (b_q),
        .product (product)
    );

    // Unsigned view of each operand adds 2^32 times the other operand when its MSB is set.
    assign fix_a  = a_q[31] ? {b_q, 32'b0} : 64'b0;
    assign fix_b  = b_q[31] ? {a_q, 32'b0} : 64'b0;
    assign result = unsigned_q ? (product + fix_a + fix_b) : product;

    always_comb begin
        // NOTE: every next value defaults to hold (or idle) first, so no latch can be inferred.
        state_d    = state_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        a_d        = a_q;
        b_d        = b_q;
        unsigned_d = unsigned_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op_e)
                        OP_MULT, OP_MULTU: begin
                            a_d        = in_a;
                            b_d        = in_b;
                            unsigned_d = (op_e == OP_MULTU);
                            count_d    = COUNT_LOAD;
                            busy_d     = 1'b1;
                            state_d    = S_BUSY;
                        end
                        OP_MTHI: hi_d = in_a;
                        OP_MTLO: lo_d = in_a;
                    endcase
                end
            end
            S_BUSY: begin
                // Any start arriving here is dropped; the issuing stage holds it until idle.
                if (count_q == 4'd0) begin
                    hi_d    = result[63:32];
                    lo_d    = result[31:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!resetn) begin
            state_q    <= S_IDLE;
            count_q    <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            unsigned_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            a_q        <= a_d;
            b_q        <= b_d;
            unsigned_q <= unsigned_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: reset, signed/unsigned products, corner operands,
// busy isolation, back-to-back issue, abort, and a MULT_CYCLES=1 instance.

module tb_mult_hilo_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start1;
    logic [1:0]  op1;
    logic [31:0] in_a1;
    logic [31:0] in_b1;
    logic        busy1;
    logic        done1;
    logic [31:0] hi1;
    logic [31:0] lo1;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int busy_seen = 0;

    always #5 clock = ~clock;

    mult_hilo_unit #(.MULT_CYCLES(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .in_a   (in_a),
        .in_b   (in_b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    mult_hilo_unit #(.MULT_CYCLES(1)) dut1 (
        .clock  (clock),
        .resetn (resetn),
        .start  (start1),
        .op     (op1),
        .in_a   (in_a1),
        .in_b   (in_b1),
        .busy   (busy1),
        .done   (done1),
        .hi     (hi1),
        .lo     (lo1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled at the rising edge,
    // outputs are observed at the following falling edge.
    task automatic step();
        @(negedge clock);
        if (done) done_seen++;
        if (busy) busy_seen++;
    endtask

    // Issue a multiply, scramble the inputs while busy, and land in the done cycle.
    task automatic run_mul(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int d0;
        int b0;
        d0    = done_seen;
        b0    = busy_seen;
        start = 1'b1;
        op    = o;
        in_a  = a;
        in_b  = b;
        step();
        start = 1'b0;
        in_a  = ~a;
        in_b  = ~b;
        repeat (4) step();
        check({tag, "_hi"}, hi, exp[63:32]);
        check({tag, "_lo"}, lo, exp[31:0]);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_seen - b0), 32'd4);
        check({tag, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        resetn = 1'b0;
        start  = 1'b1;
        op     = OP_MULT;
        in_a   = 32'h1234_5678;
        in_b   = 32'h9ABC_DEF0;
        start1 = 1'b1;
        op1    = OP_MTHI;
        in_a1  = 32'hCAFE_F00D;
        in_b1  = 32'h0;

        // 1. Reset held two cycles with start asserted.
        step();
        step();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst1_hi", hi1, 32'h0);
        check("rst1_busy", 32'(busy1), 32'd0);
        resetn    = 1'b1;
        start     = 1'b0;
        start1    = 1'b0;
        done_seen = 0;
        busy_seen = 0;

        // MULT -3 x 7, with an early look before the final edge.
        start = 1'b1;
        op    = OP_MULT;
        in_a  = 32'hFFFF_FFFD;
        in_b  = 32'h0000_0007;
        step();
        start = 1'b0;
        check("m37_busy_e0", 32'(busy), 32'd1);
        repeat (3) step();
        check("m37_lo_early", lo, 32'h0);
        check("m37_done_early", 32'(done), 32'd0);
        step();
        check("m37_hi", hi, 32'hFFFF_FFFF);
        check("m37_lo", lo, 32'hFFFF_FFEB);
        check("m37_done", 32'(done), 32'd1);
        check("m37_busy_after", 32'(busy), 32'd0);
        step();
        check("m37_done_clear", 32'(done), 32'd0);
        check("m37_done_pulses", 32'(done_seen), 32'd1);
        check("m37_busy_cycles", 32'(busy_seen), 32'd4);

        // 2. Signed vs unsigned.
        run_mul("multu_m1x2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h00000001_FFFFFFFE);
        step();
        run_mul("mult_m1x2", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFE);
        step();

        // 3. Corner operands.
        run_mul("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000);
        step();
        run_mul("multu_min", OP_MULTU, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000);
        step();
        run_mul("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001);
        step();

        // 4. MTHI in idle, then busy isolation.
        start = 1'b1;
        op    = OP_MTHI;
        in_a  = 32'hAAAA_5555;
        step();
        start = 1'b0;
        check("mthi_hi", hi, 32'hAAAA_5555);
        check("mthi_lo_hold", lo, 32'h0000_0001);
        check("mthi_done", 32'(done), 32'd0);
        d0    = done_seen;
        start = 1'b1;
        op    = OP_MULT;
        in_a  = 32'h0000_0003;
        in_b  = 32'h0000_0005;
        step();
        op    = OP_MTLO;
        in_a  = 32'h1234_5678;
        in_b  = 32'hFFFF_FFFF;
        step();
        check("iso_hi_stable", hi, 32'hAAAA_5555);
        in_a  = 32'h7FFF_FFFF;
        in_b  = 32'h7FFF_FFFF;
        step();
        start = 1'b0;
        step();
        check("iso_lo_stable", lo, 32'h0000_0001);
        step();
        check("iso_hi", hi, 32'h0);
        check("iso_lo", lo, 32'h0000_000F);
        check("iso_done", 32'(done), 32'd1);
        step();
        check("iso_done_pulses", 32'(done_seen - d0), 32'd1);
        check("iso_idle", 32'(busy), 32'd0);
        start = 1'b1;
        op    = OP_MTLO;
        in_a  = 32'h1234_5678;
        step();
        start = 1'b0;
        check("mtlo_lo", lo, 32'h1234_5678);
        check("mtlo_hi_hold", hi, 32'h0);
        check("mtlo_done", 32'(done), 32'd0);
        check("mtlo_busy", 32'(busy), 32'd0);

        // 5. Back-to-back: second start lands in the done cycle of the first.
        d0 = done_seen;
        run_mul("b2b_first", OP_MULT, 32'h0000_0009, 32'hFFFF_FFFE, 64'hFFFFFFFF_FFFFFFEE);
        run_mul("b2b_second", OP_MULT, 32'h0000_0005, 32'h0000_0006, 64'h00000000_0000001E);
        step();
        check("b2b_done_clear", 32'(done), 32'd0);
        check("b2b_done_total", 32'(done_seen - d0), 32'd2);

        // 6. Abort by reset in the second busy cycle.
        d0    = done_seen;
        start = 1'b1;
        op    = OP_MULT;
        in_a  = 32'h0000_0005;
        in_b  = 32'h0000_0006;
        step();
        start = 1'b0;
        step();
        check("abort_busy_pre", 32'(busy), 32'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_done", 32'(done), 32'd0);
        repeat (5) step();
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        check("abort_lo_hold", lo, 32'h0);

        // 6b. MULT_CYCLES=1 instance: reset with start high, then MULT -3 x 7.
        resetn = 1'b0;
        start1 = 1'b1;
        op1    = OP_MULT;
        in_a1  = 32'h0000_0011;
        in_b1  = 32'h0000_0022;
        step();
        step();
        resetn = 1'b1;
        check("mc1_rst_lo", lo1, 32'h0);
        check("mc1_rst_done", 32'(done1), 32'd0);
        in_a1 = 32'hFFFF_FFFD;
        in_b1 = 32'h0000_0007;
        step();
        start1 = 1'b0;
        in_a1  = 32'h0;
        in_b1  = 32'h0;
        check("mc1_busy", 32'(busy1), 32'd1);
        check("mc1_done_early", 32'(done1), 32'd0);
        step();
        check("mc1_hi", hi1, 32'hFFFF_FFFF);
        check("mc1_lo", lo1, 32'hFFFF_FFEB);
        check("mc1_done", 32'(done1), 32'd1);
        check("mc1_busy_after", 32'(busy1), 32'd0);
        step();
        check("mc1_done_clear", 32'(done1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
